i2c_bus_recovery: RTL and testbench

Multi-channel, parametrised I2C bus recovery engine for the CPLD's I2C segments. On request it clocks SCL on one selected channel until the slave releases SDA, up to a configurable pulse limit, and then issues a STOP condition. It reports the pulse count and a stuck flag. It is timed from the shared slow-clock enable and sits between the board-control register file and the open-drain pad drivers of each bus.

---
 rtl/i2c_bus_recovery_if.sv | 30 +++
 rtl/i2c_bus_recovery.sv | 160 ++++++++++++++++
 tb/tb_i2c_bus_recovery.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_recovery_if.sv
// Control and bus signal bundle for the I2C bus recovery engine.
// The master side is the register file / pad wrapper; the slave side is the engine.
interface i2c_bus_recovery_if #(
  parameter int CHANNELS   = 2,
  parameter int MAX_PULSES = 9
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = $clog2(MAX_PULSES + 1);

  logic                ce;
  logic                start;
  logic [SELW-1:0]     sel;
  logic [CHANNELS-1:0] sda;
  logic [CHANNELS-1:0] sda_out;
  logic [CHANNELS-1:0] scl_out;
  logic                busy;
  logic                done;
  logic                stuck;
  logic [PW-1:0]       pulses;

  modport master (
    output ce, start, sel, sda,
    input  sda_out, scl_out, busy, done, stuck, pulses
  );

  modport slave (
    input  ce, start, sel, sda,
    output sda_out, scl_out, busy, done, stuck, pulses
  );
endinterface

// File: rtl/i2c_bus_recovery.sv
// I2C bus recovery engine: toggles SCL on one channel until the slave lets
// SDA go high (or a pulse limit is hit), then issues a STOP condition.
module i2c_bus_recovery #(
  parameter int CHANNELS    = 2,
  parameter int MAX_PULSES  = 9,
  parameter int HALF_PERIOD = 1
) (
  input  logic              clk,
  input  logic              rst,
  i2c_bus_recovery_if.slave bus
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = $clog2(MAX_PULSES + 1);
  localparam int TW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, SCL_LOW, SCL_HIGH, STOP_LOW, STOP_SCL, STOP_SDA, FINISH
  } state_t;

  state_t              state;
  logic [TW-1:0]       tick;
  logic [CHANNELS-1:0] ch_mask;
  logic [CHANNELS-1:0] scl_q;
  logic [CHANNELS-1:0] sda_q;
  logic                busy_q;
  logic                done_q;
  logic                stuck_q;
  logic [PW-1:0]       pulses_q;

  logic [CHANNELS-1:0] sel_onehot;
  logic                sel_valid;
  logic                ch_sda;
  logic                timed;
  logic                phase_end;

  // Decode the selector into a channel mask and flag out-of-range values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_onehot = '0;
    sel_valid  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.sel == SELW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_valid     = 1'b1;
      end
    end
  end

  assign ch_sda    = |(bus.sda & ch_mask);
  assign timed     = (state == SCL_LOW) || (state == SCL_HIGH) || (state == STOP_LOW) ||
                     (state == STOP_SCL) || (state == STOP_SDA);
  assign phase_end = bus.ce && (tick == TW'(HALF_PERIOD - 1));

  // Recovery sequencer; all outputs are registered and change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state    <= IDLE;
      tick     <= '0;
      ch_mask  <= '0;
      scl_q    <= '1;
      sda_q    <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stuck_q  <= 1'b0;
      pulses_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (timed && bus.ce) begin
        tick <= phase_end ? '0 : tick + 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q   <= 1'b1;
            pulses_q <= '0;
            stuck_q  <= 1'b0;
            ch_mask  <= sel_onehot;
            tick     <= '0;
            if (sel_valid) begin
              state <= CHECK;
            end else begin
              // Nonexistent bus: report failure without touching any line.
              stuck_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= FINISH;
            end
          end
        end
        CHECK: begin
          if (bus.ce) begin
            scl_q <= ~ch_mask;
            if (ch_sda) begin
              sda_q <= ~ch_mask;
              state <= STOP_LOW;
            end else begin
              state <= SCL_LOW;
            end
          end
        end
        SCL_LOW: begin
          if (phase_end) begin
            scl_q <= '1;
            if (pulses_q != PW'(MAX_PULSES)) begin
              pulses_q <= pulses_q + 1'b1;
            end
            state <= SCL_HIGH;
          end
        end
        SCL_HIGH: begin
          if (phase_end) begin
            if (ch_sda) begin
              scl_q <= ~ch_mask;
              sda_q <= ~ch_mask;
              state <= STOP_LOW;
            end else if (pulses_q == PW'(MAX_PULSES)) begin
              // Slave never let go: give up with both lines already released.
              stuck_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= FINISH;
            end else begin
              scl_q <= ~ch_mask;
              state <= SCL_LOW;
            end
          end
        end
        STOP_LOW: begin
          if (phase_end) begin
            scl_q <= '1;
            state <= STOP_SCL;
          end
        end
        STOP_SCL: begin
          if (phase_end) begin
            sda_q <= '1;
            state <= STOP_SDA;
          end
        end
        STOP_SDA: begin
          if (phase_end) begin
            done_q <= 1'b1;
            state  <= FINISH;
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.scl_out = scl_q;
  assign bus.sda_out = sda_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.stuck   = stuck_q;
  assign bus.pulses  = pulses_q;
endmodule

// File: tb/tb_i2c_bus_recovery.sv
// Self-checking bench for i2c_bus_recovery: a timed-segment reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized traffic.
`timescale 1ns/1ps
module tb_i2c_bus_recovery;
  localparam int CH   = 2;
  localparam int MAXP = 9;
  localparam int HP   = 2;

  logic clk;
  logic rst;

  i2c_bus_recovery_if #(.CHANNELS(CH), .MAX_PULSES(MAXP)) bus ();
  i2c_bus_recovery_if #(.CHANNELS(1),  .MAX_PULSES(MAXP)) if1 ();

  i2c_bus_recovery #(.CHANNELS(CH), .MAX_PULSES(MAXP), .HALF_PERIOD(HP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  i2c_bus_recovery #(.CHANNELS(1), .MAX_PULSES(MAXP), .HALF_PERIOD(HP)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of timed line segments ----------------
  typedef struct {
    int ticks;     // ce ticks this segment lasts
    bit scl_low;
    bit sda_low;
    bit count;     // completes one SCL pulse when it ends
    bit decide;    // sample SDA when it ends
    bit last;      // sequence finishes when it ends
  } seg_t;

  seg_t segq[$];
  seg_t m_s;
  int   m_ch     = 0;
  bit   m_busy   = 0;
  bit   m_done   = 0;
  bit   m_stuck  = 0;
  bit   m_fin    = 0;
  int   m_pulses = 0;

  function automatic seg_t mk(int t, bit sl, bit dl, bit c, bit d, bit l);
    seg_t s;
    s.ticks = t; s.scl_low = sl; s.sda_low = dl; s.count = c; s.decide = d; s.last = l;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      segq.delete();
      m_busy = 0; m_done = 0; m_stuck = 0; m_fin = 0; m_pulses = 0;
    end else begin
      m_done = 0;
      if (m_fin) begin
        m_fin  = 0;
        m_busy = 0;
      end else if (!m_busy) begin
        if (bus.start) begin
          m_busy = 1; m_pulses = 0; m_stuck = 0;
          m_ch = int'(bus.sel);
          segq.push_back(mk(1, 0, 0, 0, 1, 0));
        end
      end else if (bus.ce && segq.size() > 0) begin
        m_s = segq.pop_front();
        m_s.ticks--;
        if (m_s.ticks > 0) begin
          segq.push_front(m_s);
        end else begin
          if (m_s.count && m_pulses < MAXP) m_pulses++;
          if (m_s.last) begin
            m_done = 1; m_fin = 1;
          end else if (m_s.decide) begin
            if (bus.sda[m_ch]) begin
              segq.push_back(mk(HP, 1, 1, 0, 0, 0));
              segq.push_back(mk(HP, 0, 1, 0, 0, 0));
              segq.push_back(mk(HP, 0, 0, 0, 0, 1));
            end else if (m_pulses >= MAXP) begin
              m_stuck = 1; m_done = 1; m_fin = 1;
            end else begin
              segq.push_back(mk(HP, 1, 0, 1, 0, 0));
              segq.push_back(mk(HP, 0, 0, 0, 1, 0));
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare, monitor and stimulus ----------------
  int falls[CH], stops[CH], lowcyc[CH], lastlow[CH], lowrun[CH];
  int b_falls[CH], b_stops[CH], b_low[CH];
  int rel_after[CH];
  int dones = 0, b_dones = 0, low1 = 0;
  logic [CH-1:0] pscl = '1, psda = '1;
  bit ce_random = 0;
  int cyc = 0;

  task automatic compare_outputs();
    logic [CH-1:0] e_scl, e_sda;
    seg_t f;
    e_scl = '1;
    e_sda = '1;
    if (m_busy && segq.size() > 0) begin
      f = segq[0];
      e_scl[m_ch] = ~f.scl_low;
      e_sda[m_ch] = ~f.sda_low;
    end
    check("scl_out", 32'(bus.scl_out), 32'(e_scl));
    check("sda_out", 32'(bus.sda_out), 32'(e_sda));
    check("busy",    32'(bus.busy),    32'(m_busy));
    check("done",    32'(bus.done),    32'(m_done));
    check("stuck",   32'(bus.stuck),   32'(m_stuck));
    check("pulses",  32'(bus.pulses),  32'(m_pulses));
  endtask

  task automatic monitor();
    for (int c = 0; c < CH; c++) begin
      if (!bus.scl_out[c] || !bus.sda_out[c]) lowcyc[c]++;
      if (!bus.scl_out[c]) lowrun[c]++;
      else if (!pscl[c]) begin
        lastlow[c] = lowrun[c];
        lowrun[c]  = 0;
      end
      if (pscl[c] && !bus.scl_out[c] && bus.sda_out[c]) falls[c]++;
      if (!psda[c] && pscl[c] && bus.sda_out[c] && bus.scl_out[c]) stops[c]++;
    end
    if (bus.done) dones++;
    if (if1.scl_out !== 1'b1 || if1.sda_out !== 1'b1) low1++;
    pscl = bus.scl_out;
    psda = bus.sda_out;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    monitor();
    #1;
    cyc++;
    bus.ce = ce_random ? ($urandom_range(0, 1) == 0) : (cyc % 4 == 0);
    if1.ce = bus.ce;
    for (int c = 0; c < CH; c++) bus.sda[c] = ((falls[c] - b_falls[c]) >= rel_after[c]);
  endtask

  task automatic snapshot();
    for (int c = 0; c < CH; c++) begin
      b_falls[c] = falls[c];
      b_stops[c] = stops[c];
      b_low[c]   = lowcyc[c];
    end
    b_dones = dones;
  endtask

  task automatic launch(input int s);
    bus.sel   = s[0];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    check("done_in_budget", 32'(n < budget), 32'd1);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.ce = 1'b0; bus.start = 1'b0; bus.sel = 1'b0; bus.sda = '1;
    if1.ce = 1'b0; if1.start = 1'b0; if1.sel = 1'b0; if1.sda = 1'b1;
    for (int c = 0; c < CH; c++) rel_after[c] = 0;
    repeat (3) tick();
    check("rst_scl",    32'(bus.scl_out), 32'h3);
    check("rst_sda",    32'(bus.sda_out), 32'h3);
    check("rst_busy",   32'(bus.busy),    32'd0);
    check("rst_pulses", 32'(bus.pulses),  32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Idle bus on channel 0: no pulses, one STOP.
    snapshot();
    launch(0);
    check("busy_rise", 32'(bus.busy), 32'd1);
    wait_done(200);
    check("idle_pulses", 32'(bus.pulses), 32'd0);
    check("idle_stuck",  32'(bus.stuck),  32'd0);
    check("idle_falls",  32'(falls[0] - b_falls[0]), 32'd0);
    check("idle_stops",  32'(stops[0] - b_stops[0]), 32'd1);
    check("idle_ch1",    32'(lowcyc[1] - b_low[1]),  32'd0);
    check("idle_busy",   32'(bus.busy), 32'd0);

    // Slave on channel 1 releases after 3 pulses.
    rel_after[1] = 3;
    snapshot();
    launch(1);
    wait_done(400);
    check("rel3_pulses", 32'(bus.pulses), 32'd3);
    check("rel3_stuck",  32'(bus.stuck),  32'd0);
    check("rel3_falls",  32'(falls[1] - b_falls[1]), 32'd3);
    check("rel3_stops",  32'(stops[1] - b_stops[1]), 32'd1);
    check("rel3_half",   32'(lastlow[1]), 32'd8);
    check("rel3_ch0",    32'(lowcyc[0] - b_low[0]),  32'd0);
    rel_after[1] = 0;
    repeat (3) tick();

    // Stuck bus on channel 0.
    rel_after[0] = 100;
    snapshot();
    launch(0);
    wait_done(600);
    check("stuck_pulses", 32'(bus.pulses), 32'd9);
    check("stuck_flag",   32'(bus.stuck),  32'd1);
    check("stuck_falls",  32'(falls[0] - b_falls[0]), 32'd9);
    check("stuck_stops",  32'(stops[0] - b_stops[0]), 32'd0);
    check("stuck_scl",    32'(bus.scl_out), 32'h3);
    check("stuck_sda",    32'(bus.sda_out), 32'h3);
    rel_after[0] = 0;
    repeat (3) tick();

    // Invalid selector on the single-channel build.
    if1.sel = 1'b1;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    n = 0;
    while (!if1.done && n < 4) begin
      tick();
      n++;
    end
    check("inv_done_fast", 32'(n <= 1), 32'd1);
    check("inv_stuck",     32'(if1.stuck),  32'd1);
    check("inv_pulses",    32'(if1.pulses), 32'd0);
    tick();
    check("inv_busy", 32'(if1.busy), 32'd0);

    // Re-trigger during pulse 2 is ignored.
    rel_after[0] = 4;
    snapshot();
    launch(0);
    n = 0;
    while ((falls[0] - b_falls[0]) < 2 && n < 200) begin
      tick();
      n++;
    end
    check("retrig_reach", 32'(n < 200), 32'd1);
    bus.sel = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(400);
    check("retrig_pulses", 32'(bus.pulses), 32'd4);
    check("retrig_dones",  32'(dones - b_dones), 32'd1);
    check("retrig_stops",  32'(stops[0] - b_stops[0]), 32'd1);
    check("retrig_ch1",    32'(lowcyc[1] - b_low[1]), 32'd0);
    repeat (3) tick();

    // Reset while SCL is held low, then a normal run.
    rel_after[0] = 100;
    snapshot();
    launch(0);
    n = 0;
    while (bus.scl_out[0] && n < 100) begin
      tick();
      n++;
    end
    check("rst_mid_reach", 32'(n < 100), 32'd1);
    rst = 1'b1;
    tick();
    check("rstm_scl",    32'(bus.scl_out), 32'h3);
    check("rstm_sda",    32'(bus.sda_out), 32'h3);
    check("rstm_busy",   32'(bus.busy),    32'd0);
    check("rstm_done",   32'(bus.done),    32'd0);
    check("rstm_stuck",  32'(bus.stuck),   32'd0);
    check("rstm_pulses", 32'(bus.pulses),  32'd0);
    rst = 1'b0;
    rel_after[0] = 0;
    tick();
    snapshot();
    launch(0);
    wait_done(200);
    check("after_rst_pulses", 32'(bus.pulses), 32'd0);
    check("after_rst_stops",  32'(stops[0] - b_stops[0]), 32'd1);

    // Randomized traffic: starts, re-triggers, irregular ce, rare resets.
    ce_random = 1;
    for (int i = 0; i < 6000; i++) begin
      if (!bus.busy) begin
        for (int c = 0; c < CH; c++) rel_after[c] = $urandom_range(0, 11);
        snapshot();
      end
      bus.start = ($urandom_range(0, 19) == 0);
      bus.sel   = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) tick();

    check("single_ch_never_driven", 32'(low1), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
